// File: rtl/galaga_clk_pkg.sv
// Shared clocking/reset types and default constants for the arcade core clock domain.
package galaga_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_STABLE = 1024;
  localparam int DEF_HOLD_CYCLES = 4096;
  localparam int DEF_CEN_DIV     = 8;

  // Counter width for a 0..n-1 range; never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop bit synchroniser with asynchronous active-high clear.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, sequences the arcade core reset and generates the 6/3 MHz clock enables.
module pll_reset_sequencer
  import galaga_clk_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CEN_DIV     = DEF_CEN_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_reset,
  input  logic pause,
  output logic core_reset,
  output logic ready,
  output logic cen_main,
  output logic cen_half
);

  localparam int SW = cw(LOCK_STABLE);
  localparam int HW = cw(HOLD_CYCLES);
  localparam int DW = cw(CEN_DIV);

  state_e          state_q, state_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   div_q, div_d;
  logic            half_q, half_d;
  logic            core_reset_q, core_reset_d;
  logic            ready_q, ready_d;
  logic            cen_main_q, cen_main_d;
  logic            cen_half_q, cen_half_d;
  logic            locked_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WAIT;
      stab_q       <= '0;
      hold_q       <= '0;
      div_q        <= '0;
      half_q       <= 1'b0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      cen_main_q   <= 1'b0;
      cen_half_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      hold_q       <= hold_d;
      div_q        <= div_d;
      half_q       <= half_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      cen_main_q   <= cen_main_d;
      cen_half_q   <= cen_half_d;
    end
  end

  // Loss of lock overrides everything, including soft reset and terminal counts.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    if (!locked_s) begin
      state_d = ST_WAIT;
      stab_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (stab_q == SW'(LOCK_STABLE - 1)) begin
            state_d = ST_HOLD;
            stab_d  = '0;
            hold_d  = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (soft_reset) begin
            hold_d = '0;
          end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (soft_reset) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Divider sits at 0 through WAIT and the HOLD-entry edge, so HOLD starts at phase 0.
  always_comb begin
    div_d  = div_q;
    half_d = half_q;
    if (state_d == ST_WAIT) begin
      div_d  = '0;
      half_d = 1'b0;
    end else if (state_q != ST_WAIT) begin
      if (div_q == DW'(CEN_DIV - 1)) begin
        div_d  = '0;
        half_d = ~half_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    cen_main_d   = (state_d != ST_WAIT) && (div_d == DW'(CEN_DIV - 1)) &&
                   !((state_d == ST_RUN) && pause);
    cen_half_d   = cen_main_d && half_d;
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign cen_main   = cen_main_q;
  assign cen_half   = cen_half_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer against an elapsed-cycle reference model.
module tb_pll_reset_sequencer;

  localparam int SS = 2;
  localparam int LS = 4;
  localparam int HC = 8;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic rst, pll_locked, soft_reset, pause;
  logic core_reset, ready, cen_main, cen_half;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .LOCK_STABLE(LS), .HOLD_CYCLES(HC), .CEN_DIV(CD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .pause      (pause),
    .core_reset (core_reset),
    .ready      (ready),
    .cen_main   (cen_main),
    .cen_half   (cen_half)
  );

  // Reference model: lock delayed by SS samples, LS consecutive good samples to qualify,
  // HC soft-reset-free cycles of hold, enables placed on an elapsed-cycle grid from hold entry.
  bit m_sync [SS];
  int m_mode;   // 0 waiting for lock, 1 holding, 2 running
  int m_hi, m_quiet, m_t;
  bit e_rst, e_rdy, e_cm, e_ch;

  function automatic void m_reset();
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    m_mode = 0; m_hi = 0; m_quiet = 0; m_t = 0;
    e_rst = 1'b1; e_rdy = 1'b0; e_cm = 1'b0; e_ch = 1'b0;
  endfunction

  function automatic void m_edge(input bit lk, input bit sr, input bit ps);
    bit ls;
    ls = m_sync[SS-1];
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = lk;
    if (!ls) begin
      m_mode = 0; m_hi = 0;
    end else if (m_mode == 0) begin
      m_hi++;
      if (m_hi == LS) begin m_mode = 1; m_quiet = 0; m_t = 0; m_hi = 0; end
    end else if (m_mode == 1) begin
      m_t++;
      m_quiet = sr ? 0 : m_quiet + 1;
      if (m_quiet == HC) m_mode = 2;
    end else begin
      m_t++;
      if (sr) begin m_mode = 1; m_quiet = 0; end
    end
    e_rst = (m_mode != 2);
    e_rdy = (m_mode == 2);
    e_cm  = (m_mode != 0) && (m_t % CD == CD - 1) && !((m_mode == 2) && ps);
    e_ch  = e_cm && (m_t % (2 * CD) == 2 * CD - 1);
  endfunction

  function automatic logic [3:0] obs();
    return {core_reset, ready, cen_main, cen_half};
  endfunction

  function automatic logic [3:0] expv();
    return {e_rst, e_rdy, e_cm, e_ch};
  endfunction

  task automatic cyc();
    @(posedge clk);
    m_edge(pll_locked, soft_reset, pause);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0; pause = 1'b0;
    m_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (obs() !== 4'b1000) begin n_err++; $display("FAIL reset_state: got %b want 1000", obs()); end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL reset_idle k=%0d: got %b want %b", k, obs(), expv()); end
      if (cen_main || cen_half || ready || !core_reset) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL reset_idle_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_lock_seq();
    int fall, first_cm, last_cm, first_ch, bad_gap;
    fall = -1; first_cm = -1; last_cm = -1; first_ch = -1; bad_gap = 0;
    pll_locked = 1'b1;
    for (int k = 0; k < 45; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL lock_seq k=%0d: got %b want %b", k, obs(), expv()); end
      if (!core_reset && fall < 0) fall = k;
      if (cen_main) begin
        if (first_cm >= 0 && k - last_cm != CD) bad_gap++;
        if (first_cm < 0) first_cm = k;
        last_cm = k;
      end
      if (cen_half && first_ch < 0) first_ch = k;
      if (cen_half && !cen_main) bad_gap++;
    end
    // Edges numbered from 0: release lands on the 14th edge.
    n_cmp++;
    if (fall != SS + LS + HC - 1) begin n_err++; $display("FAIL lock_release_edge: got %0d want %0d", fall, SS + LS + HC - 1); end
    n_cmp++;
    if (first_cm != SS + LS + CD - 2) begin n_err++; $display("FAIL first_cen_main: got %0d want %0d", first_cm, SS + LS + CD - 2); end
    n_cmp++;
    if (first_ch != SS + LS + 2 * CD - 2) begin n_err++; $display("FAIL first_cen_half: got %0d want %0d", first_ch, SS + LS + 2 * CD - 2); end
    n_cmp++;
    if (bad_gap != 0) begin n_err++; $display("FAIL lock_cadence: got %0d bad gaps want 0", bad_gap); end
  endtask

  task automatic test_glitch();
    int g, fall;
    pll_locked = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL glitch_drop k=%0d: got %b want %b", k, obs(), expv()); end
    end
    g = $urandom_range(1, LS - 1);
    fall = -1;
    for (int k = 0; k < 60; k++) begin
      pll_locked = (k != g);
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL glitch k=%0d: got %b want %b", k, obs(), expv()); end
      if (!core_reset && fall < 0) fall = k;
    end
    n_cmp++;
    if (fall != g + 1 + SS + LS + HC - 1) begin
      n_err++; $display("FAIL glitch_release_edge g=%0d: got %0d want %0d", g, fall, g + SS + LS + HC);
    end
  endtask

  task automatic test_unlock_run();
    int rise, fall, bad;
    rise = -1; fall = -1; bad = 0;
    pll_locked = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL unlock k=%0d: got %b want %b", k, obs(), expv()); end
      if (core_reset && rise < 0) rise = k;
      if (rise >= 0 && (cen_main || cen_half || ready)) bad++;
    end
    n_cmp++;
    if (rise != SS) begin n_err++; $display("FAIL unlock_edge: got %0d want %0d", rise, SS); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL unlock_quiet: got %0d active cycles want 0", bad); end
    pll_locked = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL relock k=%0d: got %b want %b", k, obs(), expv()); end
      if (!core_reset && fall < 0) fall = k;
    end
    n_cmp++;
    if (fall != SS + LS + HC - 1) begin n_err++; $display("FAIL relock_edge: got %0d want %0d", fall, SS + LS + HC - 1); end
  endtask

  task automatic test_soft();
    int len, rise, fall, last_cm, bad_gap;
    len = $urandom_range(1, 4);
    rise = -1; fall = -1; last_cm = -1; bad_gap = 0;
    for (int k = 0; k < 40; k++) begin
      soft_reset = (k >= 10 && k < 10 + len);
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL soft k=%0d: got %b want %b", k, obs(), expv()); end
      if (core_reset && rise < 0) rise = k;
      if (rise >= 0 && !core_reset && fall < 0) fall = k;
      if (cen_main) begin
        if (last_cm >= 0 && k - last_cm != CD) bad_gap++;
        last_cm = k;
      end
    end
    soft_reset = 1'b0;
    n_cmp++;
    if (rise != 10) begin n_err++; $display("FAIL soft_assert_edge: got %0d want 10", rise); end
    n_cmp++;
    if (fall != 10 + len - 1 + HC) begin n_err++; $display("FAIL soft_release_edge len=%0d: got %0d want %0d", len, fall, 9 + len + HC); end
    n_cmp++;
    if (bad_gap != 0) begin n_err++; $display("FAIL soft_cadence: got %0d bad gaps want 0", bad_gap); end
  endtask

  task automatic test_pause();
    int plen, ref_cm, misal, inpause, after;
    bit p;
    plen = $urandom_range(12, 30);
    ref_cm = -1; misal = 0; inpause = 0; after = 0;
    for (int k = 0; k < plen + 48; k++) begin
      pause = (k >= 8 && k < 8 + plen);
      p = pause;
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL pause k=%0d: got %b want %b", k, obs(), expv()); end
      if (p && (cen_main || cen_half)) inpause++;
      if (cen_main) begin
        if (ref_cm < 0) ref_cm = k;
        else if ((k - ref_cm) % CD != 0) misal++;
        if (k >= 8 + plen) after++;
      end
    end
    pause = 1'b0;
    n_cmp++;
    if (inpause != 0) begin n_err++; $display("FAIL pause_masked: got %0d enables want 0", inpause); end
    n_cmp++;
    if (misal != 0) begin n_err++; $display("FAIL pause_grid: got %0d misaligned want 0", misal); end
    n_cmp++;
    if (after < 4) begin n_err++; $display("FAIL pause_resume: got %0d enables want >=4", after); end
  endtask

  task automatic test_async_rst();
    int extra;
    pll_locked = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL arst_drop k=%0d: got %b want %b", k, obs(), expv()); end
    end
    pll_locked = 1'b1;
    for (int k = 0; k < 30 && m_mode != 1; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL arst_lock k=%0d: got %b want %b", k, obs(), expv()); end
    end
    if (m_mode != 1) begin n_cmp++; n_err++; $display("FAIL arst_hold_timeout: got no hold entry want hold"); end
    extra = $urandom_range(0, HC - 3);
    for (int k = 0; k < extra; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL arst_hold k=%0d: got %b want %b", k, obs(), expv()); end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 4'b1000) begin n_err++; $display("FAIL arst_async: got %b want 1000", obs()); end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL arst_after k=%0d: got %b want %b", k, obs(), expv()); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      pll_locked = ($urandom_range(0, 99) < 97);
      soft_reset = ($urandom_range(0, 99) < 4);
      pause      = ($urandom_range(0, 99) < 15);
      cyc();
      n_cmp++;
      if (obs() !== expv()) begin n_err++; $display("FAIL random k=%0d: got %b want %b", k, obs(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_glitch();
    test_unlock_run();
    test_soft();
    test_pause();
    test_async_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
